// File: rtl/fpu_arbiter.sv
// Two-requester round-robin front end for a fixed-latency FPU.
// Tags track ownership through the pipe; per-requester credits cap in-flight ops.
module fpu_arbiter #(
   parameter int LATENCY = 6,
   parameter int MAX_OUT = 4
) (
   input  logic        clk_i,
   input  logic        RST,

   input  logic        req0_valid_i,
   output logic        req0_ready_o,
   input  logic [31:0] req0_opa_i,
   input  logic [31:0] req0_opb_i,
   input  logic [1:0]  req0_mode_i,
   input  logic        req0_op_i,

   input  logic        req1_valid_i,
   output logic        req1_ready_o,
   input  logic [31:0] req1_opa_i,
   input  logic [31:0] req1_opb_i,
   input  logic [1:0]  req1_mode_i,
   input  logic        req1_op_i,

   output logic [31:0] fpu_opa_o,
   output logic [31:0] fpu_opb_o,
   output logic [1:0]  fpu_mode_o,
   output logic        fpu_op_o,
   input  logic [31:0] fpu_result_i,
   input  logic [3:0]  fpu_flags_i,

   output logic        rsp0_valid_o,
   output logic [31:0] rsp0_result_o,
   output logic [3:0]  rsp0_flags_o,

   output logic        rsp1_valid_o,
   output logic [31:0] rsp1_result_o,
   output logic [3:0]  rsp1_flags_o,

   output logic        busy_o
);

   localparam int CW = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);
   localparam logic [CW-1:0] ONE = CW'(1);

   typedef struct packed {
      logic valid;
      logic id;
   } tag_t;

   tag_t          tags [LATENCY];
   tag_t          tag_out;
   logic          rr_ptr;
   logic [CW-1:0] cnt0;
   logic [CW-1:0] cnt1;
   logic          elig0;
   logic          elig1;
   logic          gnt0;
   logic          gnt1;
   logic          hs;
   logic          tag_busy;

   assign elig0 = req0_valid_i && (cnt0 < MAX_CNT);
   assign elig1 = req1_valid_i && (cnt1 < MAX_CNT);

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (RST) begin
         unique case (1'b1)
            elig0 && elig1: begin
               gnt0 = !rr_ptr;
               gnt1 = rr_ptr;
            end
            elig0 && !elig1: gnt0 = 1'b1;
            !elig0 && elig1: gnt1 = 1'b1;
            default: ;
         endcase
      end
   end

   assign req0_ready_o = gnt0;
   assign req1_ready_o = gnt1;
   assign hs           = gnt0 || gnt1;
   assign tag_out      = tags[LATENCY-1];

   always_ff @(posedge clk_i or negedge RST) begin
      if (!RST) begin
         rr_ptr <= 1'b0;
      end else if (hs) begin
         rr_ptr <= gnt0;
      end
   end

   always_ff @(posedge clk_i or negedge RST) begin
      if (!RST) begin
         fpu_opa_o  <= '0;
         fpu_opb_o  <= '0;
         fpu_mode_o <= '0;
         fpu_op_o   <= 1'b0;
      end else if (gnt0) begin
         fpu_opa_o  <= req0_opa_i;
         fpu_opb_o  <= req0_opb_i;
         fpu_mode_o <= req0_mode_i;
         fpu_op_o   <= req0_op_i;
      end else if (gnt1) begin
         fpu_opa_o  <= req1_opa_i;
         fpu_opb_o  <= req1_opb_i;
         fpu_mode_o <= req1_mode_i;
         fpu_op_o   <= req1_op_i;
      end
   end

   // Bubbles enter on idle cycles so the pipe never stalls.
   always_ff @(posedge clk_i or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < LATENCY; i++) begin
            tags[i] <= '0;
         end
      end else begin
         tags[0].valid <= hs;
         tags[0].id    <= gnt1;
         for (int i = 1; i < LATENCY; i++) begin
            tags[i] <= tags[i-1];
         end
      end
   end

   always_ff @(posedge clk_i or negedge RST) begin
      if (!RST) begin
         rsp0_valid_o  <= 1'b0;
         rsp0_result_o <= '0;
         rsp0_flags_o  <= '0;
      end else begin
         rsp0_valid_o <= tag_out.valid && !tag_out.id;
         if (tag_out.valid && !tag_out.id) begin
            rsp0_result_o <= fpu_result_i;
            rsp0_flags_o  <= fpu_flags_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge RST) begin
      if (!RST) begin
         rsp1_valid_o  <= 1'b0;
         rsp1_result_o <= '0;
         rsp1_flags_o  <= '0;
      end else begin
         rsp1_valid_o <= tag_out.valid && tag_out.id;
         if (tag_out.valid && tag_out.id) begin
            rsp1_result_o <= fpu_result_i;
            rsp1_flags_o  <= fpu_flags_i;
         end
      end
   end

   // Credits return on the response strobe, one cycle after sampling.
   always_ff @(posedge clk_i or negedge RST) begin
      if (!RST) begin
         cnt0 <= '0;
      end else begin
         unique case ({gnt0, rsp0_valid_o})
            2'b10:   cnt0 <= cnt0 + ONE;
            2'b01:   cnt0 <= cnt0 - ONE;
            default: cnt0 <= cnt0;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge RST) begin
      if (!RST) begin
         cnt1 <= '0;
      end else begin
         unique case ({gnt1, rsp1_valid_o})
            2'b10:   cnt1 <= cnt1 + ONE;
            2'b01:   cnt1 <= cnt1 - ONE;
            default: cnt1 <= cnt1;
         endcase
      end
   end

   always_comb begin
      tag_busy = 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
         tag_busy = tag_busy || tags[i].valid;
      end
   end

   assign busy_o = tag_busy || (cnt0 != '0) || (cnt1 != '0);

endmodule

// File: tb/tb_fpu_arbiter.sv
// Scoreboard bench for fpu_arbiter: grant model, fake FPU delay line,
// per-requester response queues.
module tb_fpu_arbiter;

   localparam int LAT = 6;
   localparam int MO  = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid_i, req1_valid_i;
   logic        req0_ready_o, req1_ready_o;
   logic [31:0] req0_opa_i, req0_opb_i;
   logic [31:0] req1_opa_i, req1_opb_i;
   logic [1:0]  req0_mode_i, req1_mode_i;
   logic        req0_op_i, req1_op_i;
   logic [31:0] fpu_opa_o, fpu_opb_o;
   logic [1:0]  fpu_mode_o;
   logic        fpu_op_o;
   logic [31:0] fpu_result_i;
   logic [3:0]  fpu_flags_i;
   logic        rsp0_valid_o, rsp1_valid_o;
   logic [31:0] rsp0_result_o, rsp1_result_o;
   logic [3:0]  rsp0_flags_o, rsp1_flags_o;
   logic        busy_o;

   fpu_arbiter #(.LATENCY(LAT), .MAX_OUT(MO)) dut (
      .clk_i        (clk),
      .RST          (rst_n),
      .req0_valid_i (req0_valid_i),
      .req0_ready_o (req0_ready_o),
      .req0_opa_i   (req0_opa_i),
      .req0_opb_i   (req0_opb_i),
      .req0_mode_i  (req0_mode_i),
      .req0_op_i    (req0_op_i),
      .req1_valid_i (req1_valid_i),
      .req1_ready_o (req1_ready_o),
      .req1_opa_i   (req1_opa_i),
      .req1_opb_i   (req1_opb_i),
      .req1_mode_i  (req1_mode_i),
      .req1_op_i    (req1_op_i),
      .fpu_opa_o    (fpu_opa_o),
      .fpu_opb_o    (fpu_opb_o),
      .fpu_mode_o   (fpu_mode_o),
      .fpu_op_o     (fpu_op_o),
      .fpu_result_i (fpu_result_i),
      .fpu_flags_i  (fpu_flags_i),
      .rsp0_valid_o (rsp0_valid_o),
      .rsp0_result_o(rsp0_result_o),
      .rsp0_flags_o (rsp0_flags_o),
      .rsp1_valid_o (rsp1_valid_o),
      .rsp1_result_o(rsp1_result_o),
      .rsp1_flags_o (rsp1_flags_o),
      .busy_o       (busy_o)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [35:0] val;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   errs = 0;
   int   checks = 0;
   int   cyc = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [35:0] fpu_f(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [1:0] m,
                                         input logic o);
      logic [31:0] r;
      r = a ^ {b[15:0], b[31:16]} ^ {29'd0, o, m};
      return {r, a[3:0] ^ b[7:4] ^ {o, m, 1'b1}};
   endfunction

   // Fake FPU: result in cycle c is f(operands presented in cycle c-LAT+1).
   logic [35:0] pipe [LAT-1];
   always @(posedge clk) begin
      cyc <= cyc + 1;
      pipe[0] <= fpu_f(fpu_opa_o, fpu_opb_o, fpu_mode_o, fpu_op_o);
      for (int j = 1; j < LAT - 1; j++) pipe[j] <= pipe[j-1];
   end
   assign fpu_result_i = pipe[LAT-2][35:4];
   assign fpu_flags_i  = pipe[LAT-2][3:0];

   bit          rr;
   int          out0, out1;
   bit          e0, e1, g0, g1, x0, x1;
   logic [31:0] e_opa, e_opb;
   logic [1:0]  e_mode;
   logic        e_op;
   logic [35:0] l0, l1;
   exp_t        h;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_ready", {req0_ready_o, req1_ready_o}, 2'b00);
         chk("rst_rspv", {rsp0_valid_o, rsp1_valid_o}, 2'b00);
         chk("rst_busy", busy_o, 1'b0);
         chk("rst_fpu", {fpu_opa_o, fpu_opb_o}, 64'd0);
         chk("rst_rsp", {rsp0_result_o, rsp1_result_o}, 64'd0);
         rr = 0; out0 = 0; out1 = 0;
         e_opa = '0; e_opb = '0; e_mode = '0; e_op = 1'b0;
         l0 = '0; l1 = '0;
         q0.delete(); q1.delete();
      end else begin
         e0 = req0_valid_i && (out0 < MO);
         e1 = req1_valid_i && (out1 < MO);
         if (e0 && e1) begin
            g0 = !rr; g1 = rr;
         end else begin
            g0 = e0; g1 = e1;
         end
         chk("ready0", req0_ready_o, g0);
         chk("ready1", req1_ready_o, g1);
         chk("fpu_ab", {fpu_opa_o, fpu_opb_o}, {e_opa, e_opb});
         chk("fpu_ctl", {fpu_mode_o, fpu_op_o}, {e_mode, e_op});

         while (q0.size() > 0 && q0[0].cyc < cyc) begin
            chk("rsp0_due", q0[0].cyc, cyc);
            void'(q0.pop_front());
         end
         while (q1.size() > 0 && q1[0].cyc < cyc) begin
            chk("rsp1_due", q1[0].cyc, cyc);
            void'(q1.pop_front());
         end
         x0 = q0.size() > 0 && q0[0].cyc == cyc;
         x1 = q1.size() > 0 && q1[0].cyc == cyc;
         chk("rsp0_valid", rsp0_valid_o, x0);
         chk("rsp1_valid", rsp1_valid_o, x1);
         if (x0) begin h = q0.pop_front(); l0 = h.val; end
         if (x1) begin h = q1.pop_front(); l1 = h.val; end
         chk("rsp0_data", {rsp0_result_o, rsp0_flags_o}, l0);
         chk("rsp1_data", {rsp1_result_o, rsp1_flags_o}, l1);
         chk("busy", busy_o, (out0 + out1) != 0);

         if (g0) begin
            h.cyc = cyc + LAT + 1;
            h.val = fpu_f(req0_opa_i, req0_opb_i, req0_mode_i, req0_op_i);
            q0.push_back(h);
            e_opa = req0_opa_i; e_opb = req0_opb_i;
            e_mode = req0_mode_i; e_op = req0_op_i;
            out0++; rr = 1;
         end else if (g1) begin
            h.cyc = cyc + LAT + 1;
            h.val = fpu_f(req1_opa_i, req1_opb_i, req1_mode_i, req1_op_i);
            q1.push_back(h);
            e_opa = req1_opa_i; e_opb = req1_opb_i;
            e_mode = req1_mode_i; e_op = req1_op_i;
            out1++; rr = 0;
         end
         if (x0) out0--;
         if (x1) out1--;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v0, input bit v1);
      req0_valid_i = v0;
      req1_valid_i = v1;
      req0_opa_i = $urandom; req0_opb_i = $urandom;
      req1_opa_i = $urandom; req1_opb_i = $urandom;
      req0_mode_i = 2'($urandom); req1_mode_i = 2'($urandom);
      req0_op_i = 1'($urandom); req1_op_i = 1'($urandom);
      step();
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      req0_opa_i = '0; req0_opb_i = '0; req0_mode_i = '0; req0_op_i = 1'b0;
      req1_opa_i = '0; req1_opb_i = '0; req1_mode_i = '0; req1_op_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      req0_valid_i = 1'b1;
      req0_opa_i = 32'h3F80_0000; req0_opb_i = 32'h4000_0000;
      req0_mode_i = 2'd0; req0_op_i = 1'b0;
      step();
      idle(12);

      repeat (20) drive(1'b1, 1'b1);
      idle(14);

      repeat (20) drive(1'b1, 1'b0);
      idle(14);

      drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      drive(1'b1, 1'b0);
      idle(14);

      repeat (300) drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      idle(14);

      repeat (3) drive(1'b1, 1'b0);
      drive(1'b0, 1'b0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      idle(12);
      drive(1'b1, 1'b1);
      idle(14);

      chk("q0_drain", q0.size(), 0);
      chk("q1_drain", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
